wb_b3_mem_responder: RTL

- Wishbone B3 slave memory that answers the CPU-side memory bus (the mem_* master port exported from the SoC top).
- Supports the mor1kx "B3_REGISTERED_FEEDBACK" bus mode: classic cycles plus constant-address and incrementing bursts, with linear or wrap-4/8/16 addressing.
- Has configurable wait states and raises an error for out-of-range addresses.
- Serves as synthesizable main RAM and as the simulation-side responder for instruction and data fetches.

---
 rtl/wb_b3_mem_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/wb_b3_mem_responder.sv
// Wishbone B3 slave RAM with registered-feedback burst support, optional wait
// states before the first beat, and error termination for out-of-range addresses.
`timescale 1ns/1ps
module wb_b3_mem_responder #(
  parameter int unsigned MEM_SIZE      = 32'h00010000,
  parameter int unsigned WAIT_STATES   = 0,
  parameter string       MEM_INIT_FILE = ""
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int WORDS = MEM_SIZE / 4;

  typedef enum logic [1:0] {IDLE, WAIT, BEAT} state_t;

  state_t      state, state_nxt;
  logic [31:0] adr_q;
  logic        we_q;
  logic [2:0]  cti_q;
  logic [1:0]  bte_q;
  logic [3:0]  wcnt;

  logic        req;
  logic        load;
  logic        beat_go;
  logic        beat_err;
  logic [31:0] beat_adr;
  logic        do_write;

  logic [31:0] mem [0:WORDS-1];

  function automatic logic [31:0] advance(input logic [31:0] a, input logic [1:0] bte);
    advance = a;
    case (bte)
      2'b00:   advance = a + 32'd4;
      2'b01:   advance[3:2] = a[3:2] + 2'd1;
      2'b10:   advance[4:2] = a[4:2] + 3'd1;
      default: advance[5:2] = a[5:2] + 4'd1;
    endcase
  endfunction

  function automatic logic is_burst(input logic [2:0] cti);
    is_burst = (cti == 3'b001) || (cti == 3'b010);
  endfunction

  assign req      = wb_cyc_i & wb_stb_i;
  assign wb_rty_o = 1'b0;
  assign do_write = (state == BEAT) && wb_ack_o && req && we_q;

  // beat_go marks an edge that launches a beat; beat_adr is the address that beat serves
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    beat_go   = 1'b0;
    beat_adr  = adr_q;
    case (state)
      IDLE: begin
        if (req && !wb_ack_o && !wb_err_o) begin
          load     = 1'b1;
          beat_adr = wb_adr_i;
          if (WAIT_STATES == 0) begin
            state_nxt = BEAT;
            beat_go   = 1'b1;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (wcnt == 4'd1) begin
          state_nxt = BEAT;
          beat_go   = 1'b1;
        end
      end
      BEAT: begin
        if (wb_err_o || !req || !is_burst(cti_q) || !is_burst(wb_cti_i)) begin
          state_nxt = IDLE;
        end else begin
          beat_go  = 1'b1;
          beat_adr = (wb_cti_i == 3'b010) ? advance(adr_q, bte_q) : adr_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
    beat_err = beat_adr >= MEM_SIZE;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      adr_q    <= '0;
      we_q     <= 1'b0;
      cti_q    <= 3'b000;
      bte_q    <= 2'b00;
      wcnt     <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        adr_q <= wb_adr_i;
        we_q  <= wb_we_i;
        cti_q <= wb_cti_i;
        bte_q <= wb_bte_i;
        wcnt  <= 4'(WAIT_STATES);
      end else if (state == WAIT) begin
        wcnt <= wcnt - 4'd1;
      end else if (state == BEAT && beat_go) begin
        adr_q <= beat_adr;
        cti_q <= wb_cti_i;
      end
      // Read data is fetched for the beat being launched so it lines up with ack
      wb_ack_o <= beat_go && !beat_err;
      wb_err_o <= beat_go && beat_err;
      wb_dat_o <= (beat_go && !beat_err) ? mem[beat_adr[AW-1:2]] : 32'd0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (wb_sel_i[i]) mem[adr_q[AW-1:2]][8*i +: 8] <= wb_dat_i[8*i +: 8];
      end
    end
  end

endmodule
